sdram_responder: RTL and testbench

Synthesizable SDR SDRAM device responder: the chip-side end of the command bus driven by our SDRAM controller. It decodes {CSn,RASn,CASn,WEn} commands, tracks per-bank open rows, honours mode-register CAS latency and burst length, and serves reads and writes from a small internal array. It replaces the external SDRAM part in simulation and in FPGA loopback builds, and flags protocol violations for the controller's bench.

---
 rtl/sdram_responder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDR SDRAM chip-side responder: decodes the controller's command bus, tracks banks and mode,
// serves CL/BL-timed read and write bursts from a small array and flags protocol violations.
module sdram_responder #(
    parameter int unsigned bankBits = 2,
    parameter int unsigned rowBits  = 13,
    parameter int unsigned colBits  = 9,
    parameter int unsigned dataBits = 16,
    parameter int unsigned memBits  = 12
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  CKE,
    input  logic [3:0]            CMD,
    input  logic [bankBits-1:0]   BA,
    input  logic [rowBits-1:0]    A,
    input  logic [dataBits/8-1:0] DQM,
    inout  wire  [dataBits-1:0]   D,
    output logic                  ERR,
    output logic                  MODE_OK
);

    localparam int unsigned LANES  = dataBits / 8;
    localparam int unsigned BANKS  = 1 << bankBits;
    localparam int unsigned DEPTH  = 1 << memBits;
    localparam int unsigned ADDR_W = bankBits + rowBits + colBits;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_BST = 4'b0110;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_READ  = 2'd1,
        B_WRITE = 2'd2
    } burst_e;

    // mode, bank and burst state
    logic                 cl3;
    logic [1:0]           bl_code;
    logic [2:0]           bl_mask;
    logic [BANKS-1:0]     bank_active;
    logic [rowBits-1:0]   open_row [BANKS];
    logic                 any_active;

    burst_e               state, state_nxt;
    logic [colBits-1:0]   cur_col;
    logic [bankBits-1:0]  cur_bank;
    logic [rowBits-1:0]   cur_row;
    logic                 cur_ap;
    logic [2:0]           rem;

    // read pipeline and output stage
    logic [1:0]           pipe_v;
    logic [dataBits-1:0]  pipe_d [2];
    logic [dataBits-1:0]  dout;
    logic [LANES-1:0]     doe;
    logic [LANES-1:0]     dqm_d1;

    logic [dataBits-1:0]  mem [DEPTH];

    // command decode
    logic is_nop, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bst;
    logic mrs_fields_ok, cmd_err;
    logic acc_act, acc_rd, acc_wr, acc_pre, acc_mrs, acc_bst;
    logic pre_hits, stop, cont;

    assign is_nop = CMD[3] | (CMD == CMD_NOP);
    assign is_act = (CMD == CMD_ACT);
    assign is_rd  = (CMD == CMD_RD);
    assign is_wr  = (CMD == CMD_WR);
    assign is_pre = (CMD == CMD_PRE);
    assign is_ref = (CMD == CMD_REF);
    assign is_mrs = (CMD == CMD_MRS);
    assign is_bst = (CMD == CMD_BST);

    assign any_active    = |bank_active;
    assign mrs_fields_ok = !A[2] && !A[3] && (A[6:4] == 3'b010 || A[6:4] == 3'b011);

    always_comb begin
        cmd_err = 1'b0;
        if (!is_nop) begin
            if (!MODE_OK && !is_mrs)                     cmd_err = 1'b1;
            if (is_act && bank_active[BA])               cmd_err = 1'b1;
            if ((is_rd || is_wr) && !bank_active[BA])    cmd_err = 1'b1;
            if ((is_mrs || is_ref) && any_active)        cmd_err = 1'b1;
            if (is_mrs && !mrs_fields_ok)                cmd_err = 1'b1;
        end
    end

    assign acc_act = is_act && !cmd_err;
    assign acc_rd  = is_rd  && !cmd_err;
    assign acc_wr  = is_wr  && !cmd_err;
    assign acc_pre = is_pre && !cmd_err;
    assign acc_mrs = is_mrs && !cmd_err;
    assign acc_bst = is_bst && !cmd_err;

    always_comb begin
        bl_mask = 3'd0;
        case (bl_code)
            2'd0:    bl_mask = 3'd0;
            2'd1:    bl_mask = 3'd1;
            2'd2:    bl_mask = 3'd3;
            default: bl_mask = 3'd7;
        endcase
    end

    // a new READ/WRITE, BST or PRE of the bursting bank cuts column generation
    assign pre_hits = acc_pre && (A[10] || BA == cur_bank);
    assign stop     = acc_rd || acc_wr || acc_bst || pre_hits;
    assign cont     = (state != B_IDLE) && !stop;

    // burst FSM: state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= B_IDLE;
        end else if (CKE) begin
            state <= state_nxt;
        end
    end

    // burst FSM: next state; a new command wins over a finishing burst
    always_comb begin
        state_nxt = state;
        if (acc_rd || acc_wr) begin
            if (bl_mask == 3'd0) state_nxt = B_IDLE;
            else                 state_nxt = acc_rd ? B_READ : B_WRITE;
        end else if (stop) begin
            state_nxt = B_IDLE;
        end else if (cont && rem == 3'd1) begin
            state_nxt = B_IDLE;
        end
    end

    // burst FSM: per-edge beat controls
    logic                 beat_rd, beat_wr, beat_last, beat_ap;
    logic [colBits-1:0]   beat_col;
    logic [bankBits-1:0]  beat_bank;
    logic [rowBits-1:0]   beat_row;

    always_comb begin
        beat_rd   = 1'b0;
        beat_wr   = 1'b0;
        beat_last = 1'b0;
        beat_ap   = cur_ap;
        beat_col  = cur_col;
        beat_bank = cur_bank;
        beat_row  = cur_row;
        if (acc_rd || acc_wr) begin
            beat_rd   = acc_rd;
            beat_wr   = acc_wr;
            beat_last = (bl_mask == 3'd0);
            beat_ap   = A[10];
            beat_col  = A[colBits-1:0];
            beat_bank = BA;
            beat_row  = open_row[BA];
        end else if (cont) begin
            beat_rd   = (state == B_READ);
            beat_wr   = (state == B_WRITE);
            beat_last = (rem == 3'd1);
        end
    end

    // storage index aliases onto the low bits of {bank,row,col}
    logic [ADDR_W-1:0]        beat_addr;
    logic [memBits-1:0]       beat_idx;
    logic [colBits-1:0]       col_mask, col_nxt;
    logic                     unused_addr_bits;

    assign beat_addr        = {beat_bank, beat_row, beat_col};
    assign beat_idx         = beat_addr[memBits-1:0];
    assign unused_addr_bits = ^beat_addr[ADDR_W-1:memBits];
    assign col_mask         = colBits'(bl_mask);
    assign col_nxt          = (beat_col & ~col_mask) | ((beat_col + colBits'(1)) & col_mask);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cur_col  <= '0;
            cur_bank <= '0;
            cur_row  <= '0;
            cur_ap   <= 1'b0;
            rem      <= '0;
        end else if (CKE) begin
            if (acc_rd || acc_wr) begin
                cur_bank <= BA;
                cur_row  <= open_row[BA];
                cur_ap   <= A[10];
                rem      <= bl_mask;
            end else if (cont) begin
                rem <= rem - 3'd1;
            end
            if (beat_rd || beat_wr) cur_col <= col_nxt;
        end
    end

    // mode register and sticky error
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            MODE_OK <= 1'b0;
            ERR     <= 1'b0;
            cl3     <= 1'b0;
            bl_code <= 2'd0;
        end else if (CKE) begin
            if (cmd_err) ERR <= 1'b1;
            if (acc_mrs) begin
                MODE_OK <= 1'b1;
                cl3     <= A[4];
                bl_code <= A[1:0];
            end
        end
    end

    // bank open/close, including auto-precharge at burst end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bank_active <= '0;
            for (int b = 0; b < BANKS; b++) open_row[b] <= '0;
        end else if (CKE) begin
            for (int b = 0; b < BANKS; b++) begin
                if (acc_act && BA == bankBits'(b)) begin
                    bank_active[b] <= 1'b1;
                    open_row[b]    <= A;
                end
                if (acc_pre && (A[10] || BA == bankBits'(b))) bank_active[b] <= 1'b0;
                if (beat_last && beat_ap && beat_bank == bankBits'(b)) bank_active[b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CKE && beat_wr) begin
            for (int l = 0; l < LANES; l++) begin
                if (!DQM[l]) mem[beat_idx][8*l +: 8] <= D[8*l +: 8];
            end
        end
    end

    // CL-deep read pipeline; DQM masks the word two edges after it was sampled
    logic                 src_v;
    logic [dataBits-1:0]  src_d;

    assign src_v = cl3 ? pipe_v[1] : pipe_v[0];
    assign src_d = cl3 ? pipe_d[1] : pipe_d[0];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pipe_v    <= '0;
            pipe_d[0] <= '0;
            pipe_d[1] <= '0;
            dout      <= '0;
            doe       <= '0;
            dqm_d1    <= '0;
        end else if (CKE) begin
            dqm_d1    <= DQM;
            pipe_v    <= {pipe_v[0], beat_rd};
            pipe_d[0] <= mem[beat_idx];
            pipe_d[1] <= pipe_d[0];
            dout      <= src_d;
            doe       <= src_v ? ~dqm_d1 : '0;
            if (acc_wr) begin
                pipe_v <= '0;
                doe    <= '0;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign D[8*l +: 8] = doe[l] ? dout[8*l +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a vector table for the main command flow plus
// hand-written sequences for CKE stall, asynchronous reset and mode/refresh errors.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_BST = 4'b0110;
    // undriven bus reads back as all ones through the pull-up
    localparam logic [15:0] HIZ = 16'hFFFF;

    logic        clk;
    logic        rst_n;
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [1:0]  dqm;
    logic        tb_oe;
    logic [15:0] tb_d;
    wire  [15:0] d_bus;
    logic        err;
    logic        mode_ok;

    int checks = 0;
    int errors = 0;

    assign d_bus = tb_oe ? tb_d : 16'bz;
    pullup pu_d (d_bus);

    sdram_responder dut (
        .CLK     (clk),
        .RSTn    (rst_n),
        .CKE     (cke),
        .CMD     (cmd),
        .BA      (ba),
        .A       (a),
        .DQM     (dqm),
        .D       (d_bus),
        .ERR     (err),
        .MODE_OK (mode_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [1:0]  dqm;
        logic        drv;
        logic [15:0] wd;
        logic        chk_d;
        logic [15:0] exp_d;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                               input logic [1:0] m, input logic drv, input logic [15:0] wd,
                               input logic chk_d, input logic [15:0] expd, input logic e);
        vec_t r;
        r.cmd = c; r.ba = b; r.a = ad; r.dqm = m; r.drv = drv; r.wd = wd;
        r.chk_d = chk_d; r.exp_d = expd; r.exp_err = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are read on the next falling edge
    task automatic step(input logic k, input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                        input logic [1:0] m, input logic drv, input logic [15:0] wd);
        cke = k; cmd = c; ba = b; a = ad; dqm = m; tb_oe = drv; tb_d = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic [15:0] expd, input logic e, input logic mo);
        chk({name, " D"}, d_bus, expd);
        chk({name, " ERR"}, 16'(err), 16'(e));
        chk({name, " MODE_OK"}, 16'(mode_ok), 16'(mo));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cke = 1'b1; cmd = C_NOP; ba = '0; a = '0; dqm = '0; tb_oe = 1'b0; tb_d = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // CL=2 BL=1 single write/read
        vq.push_back(v(C_MRS, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_ACT, 2'd1, 13'h005, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_WR,  2'd1, 13'h003, 2'b00, 1'b1, 16'hBEEF, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_RD,  2'd1, 13'h003, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        // CL=3 BL=4 wrapped burst, then back-to-back reads
        vq.push_back(v(C_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_MRS, 2'd0, 13'h032, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_ACT, 2'd1, 13'h005, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_WR,  2'd1, 13'h006, 2'b00, 1'b1, 16'h0001, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b1, 16'h0002, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b1, 16'h0003, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b1, 16'h0004, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_RD,  2'd1, 13'h006, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0));
        vq.push_back(v(C_RD,  2'd1, 13'h004, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        // byte-masked write over existing data, masked read lane
        vq.push_back(v(C_WR,  2'd1, 13'h008, 2'b00, 1'b1, 16'hABCD, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b1, 16'h5555, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b1, 16'h6666, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b1, 16'h7777, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_WR,  2'd1, 13'h008, 2'b10, 1'b1, 16'h1234, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b11, 1'b1, 16'h0000, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b11, 1'b1, 16'h0000, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b11, 1'b1, 16'h0000, 1'b0, HIZ, 1'b0));
        vq.push_back(v(C_RD,  2'd1, 13'h008, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b01, 1'b0, 16'h0000, 1'b1, 16'hAB34, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h55FF, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h6666, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        // CL=2 BL=8 read cut by BST after two columns; bank 2 row 5 aliases bank 1 row 5
        vq.push_back(v(C_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_MRS, 2'd0, 13'h023, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_ACT, 2'd2, 13'h005, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_RD,  2'd2, 13'h008, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'hAB34, 1'b0));
        vq.push_back(v(C_BST, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b0));
        // READ to an idle bank: sticky error, no data
        vq.push_back(v(C_RD,  2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b1));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b1));
        vq.push_back(v(C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b1));
        vq.push_back(v(C_ACT, 2'd2, 13'h001, 2'b00, 1'b0, 16'h0000, 1'b1, HIZ, 1'b1));

        rst_n = 1'b0;
        cke = 1'b1; cmd = C_NOP; ba = '0; a = '0; dqm = '0; tb_oe = 1'b0; tb_d = '0;
        @(negedge clk);
        @(negedge clk);
        chk_out("in_reset", HIZ, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b1, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000);
        chk_out("after_reset", HIZ, 1'b0, 1'b0);

        foreach (vq[i]) begin
            step(1'b1, vq[i].cmd, vq[i].ba, vq[i].a, vq[i].dqm, vq[i].drv, vq[i].wd);
            if (vq[i].chk_d) chk($sformatf("row%0d D", i), d_bus, vq[i].exp_d);
            chk($sformatf("row%0d ERR", i), 16'(err), 16'(vq[i].exp_err));
            chk($sformatf("row%0d MODE_OK", i), 16'(mode_ok), 16'h0001);
        end

        // CKE low freezes the burst and holds D
        step(1'b1, C_RD,  2'd2, 13'h008, 2'b00, 1'b0, 16'h0000); chk_out("cke_rd",   HIZ,      1'b1, 1'b1);
        step(1'b0, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_lo1",  HIZ,      1'b1, 1'b1);
        step(1'b0, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_lo2",  HIZ,      1'b1, 1'b1);
        step(1'b1, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_w0",   16'hAB34, 1'b1, 1'b1);
        step(1'b1, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_w1",   16'h5555, 1'b1, 1'b1);
        step(1'b0, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_hold", 16'h5555, 1'b1, 1'b1);
        step(1'b1, C_BST, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_w2",   16'h6666, 1'b1, 1'b1);
        step(1'b1, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("cke_end",  HIZ,      1'b1, 1'b1);

        // reset mid-burst releases D without waiting for a clock edge
        step(1'b1, C_RD,  2'd2, 13'h008, 2'b00, 1'b0, 16'h0000);
        step(1'b1, C_NOP, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("pre_rst", 16'hAB34, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", HIZ, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, C_RD, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000);
        chk_out("cmd_before_mode", HIZ, 1'b1, 1'b0);

        do_reset();
        step(1'b1, C_MRS, 2'd0, 13'h028, 2'b00, 1'b0, 16'h0000);
        chk_out("mrs_interleave", HIZ, 1'b1, 1'b0);
        do_reset();
        step(1'b1, C_MRS, 2'd0, 13'h040, 2'b00, 1'b0, 16'h0000);
        chk_out("mrs_bad_cl", HIZ, 1'b1, 1'b0);
        do_reset();
        step(1'b1, C_MRS, 2'd0, 13'h024, 2'b00, 1'b0, 16'h0000);
        chk_out("mrs_bad_bl", HIZ, 1'b1, 1'b0);

        do_reset();
        step(1'b1, C_MRS, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0000); chk_out("mrs_ok",      HIZ, 1'b0, 1'b1);
        step(1'b1, C_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("ref_idle",    HIZ, 1'b0, 1'b1);
        step(1'b1, C_ACT, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("act_b0",      HIZ, 1'b0, 1'b1);
        step(1'b1, C_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0000); chk_out("ref_active",  HIZ, 1'b1, 1'b1);
        step(1'b1, C_MRS, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0000); chk_out("mrs_active",  HIZ, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
